// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: request pulses are latched into a sticky pending
// register and the highest-index pending bit is offered as a binary index under valid/ready.
module priority_encoder_seq #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] x,
    input  logic         ready,
    output logic [W-1:0] y,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         multi
);

    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_PRESENT = 1'b1;

    logic         state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] clr;
    logic [N-1:0] set;
    logic [W-1:0] hi_idx;
    logic         acc;

    assign acc = (state_q == ST_PRESENT) && ready;
    assign set = en ? x : '0;

    always_comb begin
        clr = '0;
        if (acc) begin
            clr[y_q] = 1'b1;
        end
    end

    // set is OR-ed after the clear so a same-cycle re-request survives the accept
    assign pend_d = (pend_q & ~clr) | set;

    always_comb begin
        hi_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pend_d[i]) begin
                hi_idx = W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (pend_d != '0) begin
                    state_d = ST_PRESENT;
                    y_d     = hi_idx;
                end
            end
            ST_PRESENT: begin
                // no pre-emption: y only moves once the current offer is accepted
                if (ready) begin
                    if (pend_d != '0) begin
                        y_d = hi_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            pend_q  <= pend_d;
        end
    end

    assign y       = y_q;
    assign valid   = (state_q == ST_PRESENT);
    assign pending = pend_q;
    assign multi   = (pend_q & (pend_q - N'(1))) != '0;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Bench for priority_encoder_seq: directed scenarios plus random traffic,
// compared against an event-set reference model.
module tb_priority_encoder_seq;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst, en, ready;
    logic [N-1:0] x;
    logic [W-1:0] y;
    logic         valid;
    logic [N-1:0] pending;
    logic         multi;

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    logic [N-1:0] m_pend;
    int           m_y;
    bit           m_valid;

    priority_encoder_seq #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .x(x), .ready(ready),
        .y(y), .valid(valid), .pending(pending), .multi(multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int highest(input logic [N-1:0] v);
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Apply one cycle of inputs, advance the model, then compare every output.
    task automatic step(input bit r, input bit e, input logic [N-1:0] xv, input bit rd);
        logic [N-1:0] np;
        rst = r; en = e; x = xv; ready = rd;
        np = m_pend;
        if (m_valid && rd) np[m_y] = 1'b0;
        if (e) np = np | xv;
        if (r) begin
            m_pend = '0; m_y = 0; m_valid = 0;
        end else begin
            if (!m_valid || rd) begin
                if (np != '0) begin
                    m_valid = 1;
                    m_y     = highest(np);
                end else begin
                    m_valid = 0;
                end
            end
            m_pend = np;
        end
        @(posedge clk);
        #1;
        check("pending", int'(pending), int'(m_pend));
        check("valid",   int'(valid),   int'(m_valid));
        check("y",       int'(y),       m_y);
        check("multi",   int'(multi),   int'($countones(m_pend) >= 2));
    endtask

    initial begin
        m_pend = '0; m_y = 0; m_valid = 0;
        rst = 1'b1; en = 1'b1; x = 8'hFF; ready = 1'b0;

        // reset dominates en/x
        step(1, 1, 8'hFF, 0);
        step(1, 1, 8'hFF, 0);
        check("rst_pending", int'(pending), 0);
        check("rst_valid",   int'(valid),   0);
        check("rst_y",       int'(y),       0);
        check("rst_multi",   int'(multi),   0);

        // single request, held offer
        step(0, 1, 8'h04, 0);
        check("one_valid", int'(valid), 1);
        check("one_y",     int'(y),     2);
        for (int i = 0; i < 4; i++) step(0, 1, 8'h00, 0);
        check("hold_y", int'(y), 2);

        // higher request arrives during offer: no pre-emption
        step(0, 1, 8'h80, 0);
        check("nopre_y",     int'(y),     2);
        check("nopre_multi", int'(multi), 1);
        step(0, 1, 8'h00, 1);
        check("acc_y",       int'(y),       7);
        check("acc_pending", int'(pending), 8'h80);
        step(0, 1, 8'h00, 1);
        check("drain_valid", int'(valid),   0);
        check("drain_pend",  int'(pending), 0);

        // back-to-back 7,2,0
        step(0, 1, 8'h85, 1);
        check("b2b_y0", int'(y), 7);
        step(0, 0, 8'h00, 1);
        check("b2b_y1", int'(y), 2);
        step(0, 0, 8'h00, 1);
        check("b2b_y2", int'(y), 0);
        check("b2b_v2", int'(valid), 1);
        step(0, 0, 8'h00, 1);
        check("b2b_end", int'(valid), 0);

        // accept and re-set of the same bit
        step(0, 1, 8'h04, 0);
        step(0, 1, 8'h04, 1);
        check("reset_bit_pend",  int'(pending), 8'h04);
        check("reset_bit_valid", int'(valid),   1);
        check("reset_bit_y",     int'(y),       2);
        step(0, 1, 8'h00, 1);

        // en=0 ignores x; reset mid-offer
        step(0, 0, 8'hFF, 0);
        check("en0_valid", int'(valid), 0);
        step(0, 1, 8'h85, 0);
        check("pre_rst_y", int'(y), 7);
        step(1, 1, 8'h00, 0);
        check("mid_rst_pend",  int'(pending), 0);
        check("mid_rst_valid", int'(valid),   0);
        check("mid_rst_y",     int'(y),       0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [N-1:0] xr;
            xr = '0;
            for (int b = 0; b < N; b++) xr[b] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                 xr, $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
